mac_frame_checker: RTL and testbench
====================================

Name: mac_frame_checker

Overview:
- Synthesisable, streaming successor to the testbench-only preamble checker.
- Checks complete Ethernet frames on a parametrised-width XGMII-style receive bus (DATA_WIDTH/8 byte lanes per cycle): start code, preamble/SFD, destination address, length/type versus payload size, min/max frame size, stray control characters and CRC-32 FCS.
- Reports a one-cycle verdict per frame and keeps good/bad frame counters.
- Sits between the PCS receive side and the MAC receive FIFO, or alongside it as a monitor.

Parameters:
- DATA_WIDTH, 64, bus width in bits; legal values 64, 128, 256.
- CTRL_WIDTH, DATA_WIDTH/8, one control bit per byte lane.
- START_CODE, 8'hFB, start control character.
- TERM_CODE, 8'hFD, terminate control character.
- PREAMBLE_CODE, 8'h55, preamble byte.
- SFD_CODE, 8'hD5, start-of-frame delimiter.
- DST_ADDR_CODE, 48'hFFFFFFFFFFFF, accepted destination address.
- CHECK_DA, 1, 1 = flag DA mismatch; 0 = DA not checked.
- MIN_FRAME_SIZE, 64, minimum bytes from DA to FCS inclusive.
- MAX_FRAME_SIZE, 1518, maximum bytes from DA to FCS inclusive.
- CNT_WIDTH, 32, frame counter width.

Ports:
- clk  in  1  clock.
- i_rst  in  1  synchronous reset, active high.
- i_rx_data  in  DATA_WIDTH  receive data; lane k = bits [8k+7:8k]; lane 0 is first on the wire.
- i_rx_ctrl  in  CTRL_WIDTH  per-lane control flag; 1 = control character.
- i_valid  in  1  bus word valid this cycle; when low the word is ignored and all state is held.
- o_frame_done  out  1  one-cycle pulse; verdict outputs valid.
- o_frame_good  out  1  frame passed all checks (qualified by o_frame_done).
- o_preamble_error  out  1  start, preamble or SFD wrong.
- o_header_error  out  1  DA mismatch (CHECK_DA=1 only).
- o_length_error  out  1  runt, oversize, or length field greater than actual payload.
- o_fcs_error  out  1  CRC-32 residue mismatch.
- o_code_error  out  1  control character other than TERM inside the frame, or START before TERM.
- o_good_cnt  out  CNT_WIDTH  frames with o_frame_good=1.
- o_bad_cnt  out  CNT_WIDTH  frames with o_frame_good=0.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE. Any frame in progress is discarded with no done pulse.
- States: IDLE, FRAME.
- IDLE -> FRAME on a valid word with lane 0 = START_CODE and ctrl[0]=1.
  - That same word must carry lanes 1..6 = PREAMBLE_CODE and lane 7 = SFD_CODE, all with ctrl=0. Otherwise preamble_error is latched and the frame is still tracked to TERM.
  - For DATA_WIDTH > 64, lanes 8 and up of the start word are frame bytes 0 onward.
- In IDLE, words without START in lane 0 are ignored. START in any other lane is ignored.
- FRAME: bytes are processed in lane order. A byte counter counts DA..FCS bytes and saturates at MAX_FRAME_SIZE+1.
  - Bytes 0-5 are compared with DST_ADDR_CODE, first byte = MSB.
  - Bytes 12-13 are latched as length_type, byte 12 = MSB.
  - Every byte before TERM updates the CRC.
- CRC: Ethernet CRC-32, reflected polynomial 0xEDB88320, init 32'hFFFFFFFF, LSB of each byte first. Computed over DA through FCS inclusive. Pass when the register equals 32'hDEBB20E3 after the last FCS byte.
- FRAME -> IDLE on the first lane with ctrl=1 and data=TERM_CODE. That lane and higher lanes are not frame data.
- Control lane != TERM inside FRAME: latch code_error and keep tracking.
- START in lane 0 while in FRAME: close the current frame with code_error, then begin a new frame from that word.
- Length rules, with bytes = count and payload = bytes-18:
  - bytes < MIN_FRAME_SIZE or bytes > MAX_FRAME_SIZE -> length_error.
  - length_type <= 1500 and length_type > payload -> length_error.
  - length_type >= 16'h0600 -> no length check.
  - 1501..1535 -> length_error.
- Verdict: registered and asserted the cycle after the word containing TERM. Error bits are valid only during the done pulse and are 0 otherwise.
  - o_frame_good = no error flag set.
  - Exactly one counter increments in the same cycle as o_frame_done. Counters saturate at all-ones.
- i_valid low in any state: no state, CRC or count change, and no done pulse.

Test Plan:
- 64-byte broadcast frame, type 16'h0800, correct FCS, DATA_WIDTH=64 -> one cycle after TERM: o_frame_done=1, o_frame_good=1, all errors 0, o_good_cnt=1.
- Same frame with preamble lane 3 = 8'h54 -> o_preamble_error=1, o_frame_good=0, o_bad_cnt=1. Repeat with FCS bit 0 flipped -> only o_fcs_error=1.
- 60-byte frame with valid FCS -> o_length_error=1. 1519-byte frame -> o_length_error=1. Length field 100 with 46-byte payload -> o_length_error=1.
- DA=48'h001122334455: CHECK_DA=1 -> o_header_error=1; CHECK_DA=0 -> o_frame_good=1.
- Good frame with i_valid low for 3 cycles mid-frame; second frame with ctrl=1/8'h07 in byte 30 -> first frame good, second o_code_error=1; counters 1/1.
- i_rst pulsed mid-frame, then a good frame; also DATA_WIDTH=128 with TERM in lane 13 -> no done pulse for the aborted frame, next frame good, o_good_cnt=1.

Source files
------------

// File: rtl/mac_frame_checker_if.sv
// Receive-side bus from the PCS: per-lane data bytes, per-lane control flags and a word valid.
interface mac_frame_checker_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   i_rx_data;
  logic [DATA_WIDTH/8-1:0] i_rx_ctrl;
  logic                    i_valid;

  modport master (output i_rx_data, i_rx_ctrl, i_valid);
  modport slave  (input  i_rx_data, i_rx_ctrl, i_valid);
endinterface

// File: rtl/mac_frame_checker.sv
// Streaming Ethernet frame checker (preamble, DA, length, code, CRC-32) with good/bad counters.
// Verdict one cycle after the TERM word; no backpressure, i_valid low freezes all state.
module mac_frame_checker #(
  parameter int          DATA_WIDTH     = 64,
  parameter int          CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter logic [7:0]  START_CODE     = 8'hFB,
  parameter logic [7:0]  TERM_CODE      = 8'hFD,
  parameter logic [7:0]  PREAMBLE_CODE  = 8'h55,
  parameter logic [7:0]  SFD_CODE       = 8'hD5,
  parameter logic [47:0] DST_ADDR_CODE  = 48'hFFFF_FFFF_FFFF,
  parameter bit          CHECK_DA       = 1'b1,
  parameter int          MIN_FRAME_SIZE = 64,
  parameter int          MAX_FRAME_SIZE = 1518,
  parameter int          CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 i_rst,
  mac_frame_checker_if.slave   i_rx,
  output logic                 o_frame_done,
  output logic                 o_frame_good,
  output logic                 o_preamble_error,
  output logic                 o_header_error,
  output logic                 o_length_error,
  output logic                 o_fcs_error,
  output logic                 o_code_error,
  output logic [CNT_WIDTH-1:0] o_good_cnt,
  output logic [CNT_WIDTH-1:0] o_bad_cnt
);

  localparam int          LANES       = CTRL_WIDTH;
  localparam int          BW          = $clog2(MAX_FRAME_SIZE + 2);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  typedef struct packed {
    logic pre;
    logic hdr;
    logic len;
    logic fcs;
    logic code;
  } err_t;

  state_t          r_state;
  logic [BW-1:0]   r_cnt;
  logic [31:0]     r_crc;
  logic [15:0]     r_len_type;
  logic            r_pre_err;
  logic            r_da_err;
  logic            r_code_err;

  state_t          w_state;
  logic [BW-1:0]   w_cnt;
  logic [31:0]     w_crc;
  logic [15:0]     w_len_type;
  logic            w_pre_err;
  logic            w_da_err;
  logic            w_code_err;
  logic            w_done;
  err_t            w_err;
  logic            w_stop;
  int              w_skip;
  int              w_idx;
  logic [7:0]      w_byte;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic len_bad(input logic [BW-1:0] cnt, input logic [15:0] lt);
    int   bytes;
    int   payload;
    logic bad;
    bytes   = int'(cnt);
    payload = bytes - 18;
    bad     = (bytes < MIN_FRAME_SIZE) || (bytes > MAX_FRAME_SIZE);
    // Length field only constrains the payload when it is a length, not an EtherType
    if (lt <= 16'd1500) begin
      if (int'(lt) > payload) bad = 1'b1;
    end else if (lt < 16'h0600) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic err_t verdict(input logic pre, input logic da, input logic code,
                                   input logic [BW-1:0] cnt, input logic [15:0] lt,
                                   input logic [31:0] crc);
    err_t e;
    e.pre  = pre;
    e.hdr  = da & CHECK_DA;
    e.len  = len_bad(cnt, lt);
    e.fcs  = (crc != CRC_RESIDUE);
    e.code = code;
    return e;
  endfunction

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_crc      = r_crc;
    w_len_type = r_len_type;
    w_pre_err  = r_pre_err;
    w_da_err   = r_da_err;
    w_code_err = r_code_err;
    w_done     = 1'b0;
    w_err      = '0;
    w_stop     = 1'b0;
    w_skip     = 0;
    w_idx      = 0;
    w_byte     = '0;
    if (i_rx.i_valid) begin
      if (i_rx.i_rx_ctrl[0] && i_rx.i_rx_data[7:0] == START_CODE) begin
        // A START while a frame is open ends that frame as a code error
        if (r_state == ST_FRAME) begin
          w_done = 1'b1;
          w_err  = verdict(r_pre_err, r_da_err, 1'b1, r_cnt, r_len_type, r_crc);
        end
        w_state    = ST_FRAME;
        w_cnt      = '0;
        w_crc      = 32'hFFFF_FFFF;
        w_len_type = '0;
        w_da_err   = 1'b0;
        w_code_err = 1'b0;
        w_pre_err  = 1'b0;
        for (int k = 1; k < 8; k++) begin
          if (i_rx.i_rx_ctrl[k] ||
              i_rx.i_rx_data[8*k +: 8] != ((k == 7) ? SFD_CODE : PREAMBLE_CODE))
            w_pre_err = 1'b1;
        end
        w_skip = 8;
      end else if (r_state == ST_IDLE) begin
        w_stop = 1'b1;
      end
      for (int k = 0; k < LANES; k++) begin
        if (!w_stop && k >= w_skip) begin
          w_byte = i_rx.i_rx_data[8*k +: 8];
          if (i_rx.i_rx_ctrl[k]) begin
            if (w_byte == TERM_CODE) begin
              w_done  = 1'b1;
              w_err   = verdict(w_pre_err, w_da_err, w_code_err, w_cnt, w_len_type, w_crc);
              w_state = ST_IDLE;
              w_stop  = 1'b1;
            end else begin
              w_code_err = 1'b1;
            end
          end else begin
            w_idx = int'(w_cnt);
            if (w_idx < 6 && w_byte != DST_ADDR_CODE[8*(5-w_idx) +: 8]) w_da_err = 1'b1;
            if (w_idx == 12) w_len_type[15:8] = w_byte;
            if (w_idx == 13) w_len_type[7:0]  = w_byte;
            w_crc = crc_byte(w_crc, w_byte);
            if (w_cnt != BW'(MAX_FRAME_SIZE + 1)) w_cnt = w_cnt + BW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_crc            <= 32'hFFFF_FFFF;
      r_len_type       <= '0;
      r_pre_err        <= 1'b0;
      r_da_err         <= 1'b0;
      r_code_err       <= 1'b0;
      o_frame_done     <= 1'b0;
      o_frame_good     <= 1'b0;
      o_preamble_error <= 1'b0;
      o_header_error   <= 1'b0;
      o_length_error   <= 1'b0;
      o_fcs_error      <= 1'b0;
      o_code_error     <= 1'b0;
      o_good_cnt       <= '0;
      o_bad_cnt        <= '0;
    end else begin
      r_state          <= w_state;
      r_cnt            <= w_cnt;
      r_crc            <= w_crc;
      r_len_type       <= w_len_type;
      r_pre_err        <= w_pre_err;
      r_da_err         <= w_da_err;
      r_code_err       <= w_code_err;
      o_frame_done     <= w_done;
      o_frame_good     <= w_done & ~|w_err;
      o_preamble_error <= w_done & w_err.pre;
      o_header_error   <= w_done & w_err.hdr;
      o_length_error   <= w_done & w_err.len;
      o_fcs_error      <= w_done & w_err.fcs;
      o_code_error     <= w_done & w_err.code;
      if (w_done) begin
        if (~|w_err) begin
          if (o_good_cnt != {CNT_WIDTH{1'b1}}) o_good_cnt <= o_good_cnt + CNT_WIDTH'(1);
        end else begin
          if (o_bad_cnt != {CNT_WIDTH{1'b1}}) o_bad_cnt <= o_bad_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_frame_checker.sv
// Bench for mac_frame_checker: directed and randomized frames on 64-bit (DA checked / unchecked) and 128-bit instances.
module tb_mac_frame_checker;

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_g[3];
  int   exp_b[3];
  logic [7:0] frm[$];

  always #5 clk = ~clk;

  mac_frame_checker_if #(.DATA_WIDTH(64))  bus64();
  mac_frame_checker_if #(.DATA_WIDTH(128)) bus128();

  // verdict vectors: [6]=done [5]=good [4]=pre [3]=hdr [2]=len [1]=fcs [0]=code
  logic [6:0]  va, vb, vc;
  logic [31:0] ga, ba, gb, bb, gc, bc;

  mac_frame_checker #(.DATA_WIDTH(64)) dut_a (
    .clk(clk), .i_rst(rst), .i_rx(bus64),
    .o_frame_done(va[6]), .o_frame_good(va[5]), .o_preamble_error(va[4]),
    .o_header_error(va[3]), .o_length_error(va[2]), .o_fcs_error(va[1]),
    .o_code_error(va[0]), .o_good_cnt(ga), .o_bad_cnt(ba));

  mac_frame_checker #(.DATA_WIDTH(64), .CHECK_DA(1'b0)) dut_b (
    .clk(clk), .i_rst(rst), .i_rx(bus64),
    .o_frame_done(vb[6]), .o_frame_good(vb[5]), .o_preamble_error(vb[4]),
    .o_header_error(vb[3]), .o_length_error(vb[2]), .o_fcs_error(vb[1]),
    .o_code_error(vb[0]), .o_good_cnt(gb), .o_bad_cnt(bb));

  mac_frame_checker #(.DATA_WIDTH(128)) dut_c (
    .clk(clk), .i_rst(rst), .i_rx(bus128),
    .o_frame_done(vc[6]), .o_frame_good(vc[5]), .o_preamble_error(vc[4]),
    .o_header_error(vc[3]), .o_length_error(vc[2]), .o_fcs_error(vc[1]),
    .o_code_error(vc[0]), .o_good_cnt(gc), .o_bad_cnt(bc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Standard Ethernet FCS over the first m bytes of the frame
  function automatic logic [31:0] fcs_of(input int m);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < m; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input int n, input logic [47:0] da, input logic [15:0] lt, input bit fcs_ok);
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(da[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
    frm.push_back(lt[15:8]);
    frm.push_back(lt[7:0]);
    while (frm.size() < n - 4) frm.push_back(8'($urandom));
    f = fcs_of(n - 4);
    for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
    if (!fcs_ok) frm[n-4] = frm[n-4] ^ 8'h01;
  endtask

  function automatic logic [6:0] model(input bit chk_da, input bit bad_pre, input bit code);
    int          n;
    logic [15:0] lt;
    logic [47:0] da;
    logic        hdr, len, fcs, good;
    n  = frm.size();
    da = '0;
    for (int i = 0; i < 6; i++) da = {da[39:0], frm[i]};
    lt   = {frm[12], frm[13]};
    len  = (n < 64) || (n > 1518) || (lt <= 16'd1500 && int'(lt) > n - 18) ||
           (lt >= 16'd1501 && lt <= 16'd1535);
    fcs  = ({frm[n-1], frm[n-2], frm[n-3], frm[n-4]} != fcs_of(n - 4));
    hdr  = chk_da && (da != BCAST);
    good = !(bad_pre || hdr || len || fcs || code);
    return {1'b1, good, bad_pre, hdr, len, fcs, code};
  endfunction

  task automatic drive(input bit w128, input logic [127:0] d, input logic [15:0] c, input logic v);
    if (w128) begin
      bus128.i_rx_data = d;
      bus128.i_rx_ctrl = c;
      bus128.i_valid   = v;
    end else begin
      bus64.i_rx_data = d[63:0];
      bus64.i_rx_ctrl = c[7:0];
      bus64.i_valid   = v;
    end
  endtask

  task automatic idle_word(input string tag);
    drive(1'b0, {16{8'h07}}, 16'hFFFF, 1'b1);
    drive(1'b1, {16{8'h07}}, 16'hFFFF, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 32'({va[6], vb[6], vc[6]}), 32'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_g[i] = 0;
      exp_b[i] = 0;
    end
    chk("rst_done", 32'({va[6], vb[6], vc[6]}), 32'd0);
    chk("rst_cnt_a", ga | ba, 32'd0);
    chk("rst_cnt_c", gc | bc, 32'd0);
  endtask

  task automatic upd(input int i, input logic good);
    if (good) exp_g[i]++;
    else exp_b[i]++;
  endtask

  // Serialize the current frame onto the wire; abort_after>0 stops after that many words
  task automatic send(input bit w128, input bit bad_pre, input int code_pos, input int gap_at,
                      input int gap_len, input int abort_after, input string tag);
    logic [8:0]   wq[$];
    logic [127:0] d;
    logic [15:0]  c;
    logic [6:0]   ea, eb, m;
    int           lanes, nw;
    bit           early;
    lanes = w128 ? 16 : 8;
    wq.push_back({1'b1, 8'hFB});
    for (int i = 1; i < 7; i++) wq.push_back({1'b0, (bad_pre && i == 3) ? 8'h54 : 8'h55});
    wq.push_back({1'b0, 8'hD5});
    foreach (frm[i]) wq.push_back((i == code_pos) ? {1'b1, 8'h07} : {1'b0, frm[i]});
    wq.push_back({1'b1, 8'hFD});
    while (wq.size() % lanes != 0) wq.push_back({1'b1, 8'h07});
    nw    = wq.size() / lanes;
    early = 1'b0;
    for (int w = 0; w < nw; w++) begin
      if (abort_after > 0 && w == abort_after) return;
      if (w == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          drive(w128, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 1'b0);
          @(posedge clk); #1;
          if (w128 ? vc[6] : (va[6] | vb[6])) early = 1'b1;
        end
      end
      d = '0;
      c = '0;
      for (int l = 0; l < lanes; l++) begin
        c[l]        = wq[w*lanes + l][8];
        d[8*l +: 8] = wq[w*lanes + l][7:0];
      end
      drive(w128, d, c, 1'b1);
      @(posedge clk); #1;
      if (w < nw - 1 && (w128 ? vc[6] : (va[6] | vb[6]))) early = 1'b1;
    end
    chk({tag, "_early_done"}, 32'(early), 32'd0);
    m  = (code_pos >= 0) ? 7'b1100001 : 7'b1111111;
    ea = model(1'b1, bad_pre, code_pos >= 0);
    if (w128) begin
      chk({tag, "_verdict_c"}, 32'(vc & m), 32'(ea & m));
      upd(2, ea[5]);
      chk({tag, "_good_cnt_c"}, gc, 32'(exp_g[2]));
      chk({tag, "_bad_cnt_c"}, bc, 32'(exp_b[2]));
    end else begin
      eb = model(1'b0, bad_pre, code_pos >= 0);
      chk({tag, "_verdict_a"}, 32'(va & m), 32'(ea & m));
      chk({tag, "_verdict_b"}, 32'(vb & m), 32'(eb & m));
      upd(0, ea[5]);
      upd(1, eb[5]);
      chk({tag, "_good_cnt_a"}, ga, 32'(exp_g[0]));
      chk({tag, "_bad_cnt_a"}, ba, 32'(exp_b[0]));
      chk({tag, "_good_cnt_b"}, gb, 32'(exp_g[1]));
      chk({tag, "_bad_cnt_b"}, bb, 32'(exp_b[1]));
    end
    idle_word(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_g[i] = 0;
      exp_b[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_verdict_a", 32'(va), 32'd0);
    chk("reset_verdict_c", 32'(vc), 32'd0);
    chk("reset_cnt_a", ga | ba, 32'd0);
    chk("reset_cnt_c", gc | bc, 32'd0);
    idle_word("idle0");

    build(64, BCAST, 16'h0800, 1'b1);     send(1'b0, 1'b0, -1, -1, 0, 0, "good64");
    build(64, BCAST, 16'h0800, 1'b1);     send(1'b0, 1'b1, -1, -1, 0, 0, "bad_pre");
    build(64, BCAST, 16'h0800, 1'b0);     send(1'b0, 1'b0, -1, -1, 0, 0, "bad_fcs");
    build(60, BCAST, 16'h0800, 1'b1);     send(1'b0, 1'b0, -1, -1, 0, 0, "runt");
    build(1519, BCAST, 16'h0800, 1'b1);   send(1'b0, 1'b0, -1, -1, 0, 0, "oversize");
    build(64, BCAST, 16'd100, 1'b1);      send(1'b0, 1'b0, -1, -1, 0, 0, "len_field");
    build(64, BCAST, 16'd1520, 1'b1);     send(1'b0, 1'b0, -1, -1, 0, 0, "len_gap");
    build(64, 48'h0011_2233_4455, 16'h0800, 1'b1); send(1'b0, 1'b0, -1, -1, 0, 0, "da_mismatch");

    build(200, BCAST, 16'h0800, 1'b1);    send(1'b0, 1'b0, -1, -1, 0, 5, "abort64");
    pulse_rst();
    build(128, BCAST, 16'h0800, 1'b1);    send(1'b0, 1'b0, -1, 4, 3, 0, "gap_good");
    build(64, BCAST, 16'h0800, 1'b1);     send(1'b0, 1'b0, 30, -1, 0, 0, "code_err");

    for (int t = 0; t < 24; t++) begin
      int          n;
      int          sel;
      logic [47:0] da;
      logic [15:0] lt;
      n   = $urandom_range(40, 1530);
      da  = ($urandom_range(0, 3) == 0) ? {16'($urandom), $urandom} : BCAST;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       lt = 16'h0800;
        1:       lt = 16'($urandom_range(0, 1500));
        2:       lt = 16'($urandom_range(1501, 1535));
        3:       lt = 16'(n - 18);
        default: lt = 16'($urandom_range(16'h0600, 16'hFFFF));
      endcase
      build(n, da, lt, $urandom_range(0, 3) != 0);
      send(1'b0, $urandom_range(0, 5) == 0, -1, $urandom_range(1, 5), $urandom_range(0, 3), 0, "rand");
    end

    build(100, BCAST, 16'h0800, 1'b1);    send(1'b1, 1'b0, -1, -1, 0, 3, "abort128");
    pulse_rst();
    build(69, BCAST, 16'h0800, 1'b1);     send(1'b1, 1'b0, -1, -1, 0, 0, "lane13_128");
    build(64, BCAST, 16'h0800, 1'b0);     send(1'b1, 1'b0, -1, 2, 2, 0, "fcs128");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
